// File: rtl/mac_feed_ctrl.sv
// Skewed feed sequencer for the 8-MAC systolic chain: drains the A-row and B FIFOs
// so row i's k-th element meets B[k] at MAC i. Optional cycle counter: MAC_FEED_PERF_EN.
module mac_feed_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROWS-1:0]       a_wrfull,
    input  logic [ROWS-1:0]       a_rdempty,
    input  logic                  b_wrfull,
    input  logic                  b_rdempty,
    input  logic [DATA_WIDTH-1:0] b_q,
    output logic [ROWS-1:0]       a_rdreq,
    output logic                  b_rdreq,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output logic                  underflow,
    output logic [15:0]           perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(VEC_LEN + ROWS + 2);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ROWS-2:0]    skew_reg;
    logic               mac_en_reg;
    logic               start_err_reg;
    logic               underflow_reg;
    logic               all_full;

    assign all_full = (&a_wrfull) & b_wrfull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && all_full) begin
                    state_next = S_CLR;
                end
            end
            S_CLR: begin
                state_next = S_FEED;
                cnt_next   = '0;
            end
            S_FEED: begin
                if (cnt_reg == CNT_W'(VEC_LEN - 1)) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            // ROWS+1 cycles: the last skewed read reaches MAC ROWS-1 and is accumulated
            S_DRAIN: begin
                if (cnt_reg == CNT_W'(ROWS)) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        mac_clr = (state_reg == S_CLR);
        b_rdreq = (state_reg == S_FEED);
        busy    = (state_reg == S_CLR) || (state_reg == S_FEED) || (state_reg == S_DRAIN);
        done    = (state_reg == S_DONE);
    end

    // Stage j of the skew register holds b_rdreq delayed j+1 cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_reg <= '0;
        end else begin
            skew_reg[0] <= b_rdreq;
            for (int j = 1; j < ROWS - 1; j++) begin
                skew_reg[j] <= skew_reg[j-1];
            end
        end
    end

    assign a_rdreq[0] = b_rdreq;
    generate
        for (genvar gi = 1; gi < ROWS; gi++) begin : g_skew_tap
            assign a_rdreq[gi] = skew_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en_reg    <= 1'b0;
            start_err_reg <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            mac_en_reg    <= b_rdreq;
            start_err_reg <= (state_reg == S_IDLE) && start && !all_full;
            if ((|(a_rdreq & a_rdempty)) || (b_rdreq && b_rdempty)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign mac_en    = mac_en_reg;
    assign mac_b     = b_q;
    assign start_err = start_err_reg;
    assign underflow = underflow_reg;

`ifdef MAC_FEED_PERF_EN
    logic [15:0] perf_cnt_reg;
    logic [15:0] perf_cycles_reg;

    // The accepting edge counts as cycle 1, so the snapshot equals start-to-done latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_reg    <= '0;
            perf_cycles_reg <= '0;
        end else begin
            if ((state_reg == S_IDLE) && (state_next == S_CLR)) begin
                perf_cnt_reg <= 16'd1;
            end else if (busy && (perf_cnt_reg != 16'hFFFF)) begin
                perf_cnt_reg <= perf_cnt_reg + 16'd1;
            end
            if ((state_reg == S_DRAIN) && (state_next == S_DONE)) begin
                perf_cycles_reg <= (perf_cnt_reg == 16'hFFFF) ? 16'hFFFF : perf_cnt_reg + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// Bench for mac_feed_ctrl: FIFO and MAC-chain models, per-cycle expected trace and
// per-pass result scoreboard consumed by an independent monitor.
module tb_mac_feed_ctrl;

    localparam int DW = 8;
    localparam int R  = 8;
    localparam int VL = 8;

`ifdef MAC_FEED_PERF_EN
    localparam logic [15:0] PERF_EXP = 16'd19;
`else
    localparam logic [15:0] PERF_EXP = 16'd0;
`endif

    typedef struct packed {
        logic [7:0][15:0] acc;
        logic [15:0]      perf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [R-1:0]  a_wrfull, a_rdempty;
    logic          b_wrfull, b_rdempty;
    logic [DW-1:0] b_q;
    logic [R-1:0]  a_rdreq;
    logic          b_rdreq, mac_clr, mac_en, busy, done, start_err, underflow;
    logic [DW-1:0] mac_b;
    logic [15:0]   perf_cycles;

    mac_feed_ctrl #(.DATA_WIDTH(DW), .ROWS(R), .VEC_LEN(VL)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_wrfull(a_wrfull), .a_rdempty(a_rdempty),
        .b_wrfull(b_wrfull), .b_rdempty(b_rdempty), .b_q(b_q),
        .a_rdreq(a_rdreq), .b_rdreq(b_rdreq),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_b(mac_b),
        .busy(busy), .done(done), .start_err(start_err),
        .underflow(underflow), .perf_cycles(perf_cycles)
    );

    // FIFO models
    logic [7:0] a_mem [8][8];
    int         a_cnt [8];
    int         a_rp  [8];
    logic [7:0] a_q   [8];
    logic [7:0] b_mem [8];
    int         b_cnt = 0;
    int         b_rp  = 0;
    logic       refill = 1'b0;
    int         fill_mode = 0;
    logic       force_a3 = 1'b0;
    logic       force_b_empty = 1'b0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            a_cnt[i] = 0;
            a_rp[i]  = 0;
        end
    end

    always_comb begin
        a_wrfull  = '0;
        a_rdempty = '0;
        for (int i = 0; i < R; i++) begin
            a_wrfull[i]  = (a_cnt[i] == VL) && !(i == 3 && force_a3);
            a_rdempty[i] = (a_cnt[i] == 0);
        end
        b_wrfull  = (b_cnt == VL);
        b_rdempty = (b_cnt == 0) || force_b_empty;
    end

    always @(posedge clk) begin
        if (refill) begin
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < 8; k++) begin
                    a_mem[i][k] <= (fill_mode == 0) ? 8'd1 : 8'(i + k + 1);
                end
                a_cnt[i] <= VL;
                a_rp[i]  <= 0;
                b_mem[i] <= 8'(i + 1);
            end
            b_cnt <= VL;
            b_rp  <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (a_rdreq[i] && a_cnt[i] > 0) begin
                    a_q[i]   <= a_mem[i][a_rp[i]];
                    a_rp[i]  <= a_rp[i] + 1;
                    a_cnt[i] <= a_cnt[i] - 1;
                end
            end
            if (b_rdreq && b_cnt > 0) begin
                b_q   <= b_mem[b_rp];
                b_rp  <= b_rp + 1;
                b_cnt <= b_cnt - 1;
            end
        end
    end

    // MAC chain model: MAC i sees enable and B delayed i cycles
    logic       en_p [8];
    logic [7:0] b_p  [8];
    int         acc_m [8];

    always @(posedge clk) begin
        en_p[0] <= mac_en;
        b_p[0]  <= mac_b;
        for (int i = 1; i < 8; i++) begin
            en_p[i] <= en_p[i-1];
            b_p[i]  <= b_p[i-1];
        end
        if (mac_clr === 1'b1) begin
            for (int i = 0; i < 8; i++) acc_m[i] <= 0;
        end else begin
            if (mac_en === 1'b1) acc_m[0] <= acc_m[0] + int'(a_q[0]) * int'(mac_b);
            for (int i = 1; i < 8; i++) begin
                if (en_p[i-1] === 1'b1) acc_m[i] <= acc_m[i] + int'(a_q[i]) * int'(b_p[i-1]);
            end
        end
    end

    logic [14:0] trace_q [$];
    res_t        res_q [$];
    logic        stim_done = 1'b0;
    int          total = 0;
    int          bad = 0;

    // Expected outputs c cycles after the start-sampling edge (kind 0: accepted pass, 1: refused)
    function automatic logic [14:0] exp_vec(input int c, input int kind, input int abort_at,
                                            input int uf_at, input bit uf_init);
        logic [7:0] a;
        logic uf, busy_e, done_e, clr_e, en_e, brd_e, serr_e;
        a = '0; busy_e = 0; done_e = 0; clr_e = 0; en_e = 0; brd_e = 0; serr_e = 0;
        uf = uf_init || (uf_at >= 0 && c >= uf_at);
        if (kind == 0) begin
            clr_e  = (c == 1);
            brd_e  = (c >= 2 && c <= 9);
            en_e   = (c >= 3 && c <= 10);
            busy_e = (c >= 1 && c <= 18);
            done_e = (c == 19);
            for (int i = 0; i < 8; i++) a[i] = (c >= 2 + i && c <= 9 + i);
        end else begin
            serr_e = (c == 1);
        end
        if (abort_at >= 0 && c >= abort_at) return '0;
        return {serr_e, uf, busy_e, done_e, clr_e, en_e, brd_e, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifos(input int mode);
        fill_mode = mode;
        refill = 1'b1;
        tick();
        refill = 1'b0;
    endtask

    task automatic run_pass(input int kind, input int mode, input int restart_at, input int abort_at,
                            input int empty_at, input bit uf_init, input int refill_at,
                            input int refill_mode, input int ncyc);
        res_t r;
        for (int c = 0; c < ncyc; c++) begin
            trace_q.push_back(exp_vec(c, kind, abort_at, (empty_at >= 0) ? empty_at + 1 : -1, uf_init));
        end
        if (kind == 0 && abort_at < 0) begin
            for (int i = 0; i < 8; i++) r.acc[i] = (mode == 0) ? 16'd36 : 16'(204 + 36 * i);
            r.perf = PERF_EXP;
            res_q.push_back(r);
        end
        for (int c = 0; c < ncyc; c++) begin
            start         = (c == 0) || (c == restart_at);
            rst           = (c == abort_at);
            force_b_empty = (c == empty_at);
            if (c == refill_at) begin
                fill_mode = refill_mode;
                refill    = 1'b1;
            end else begin
                refill = 1'b0;
            end
            tick();
        end
        start = 0; rst = 0; force_b_empty = 0; refill = 0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tick();
        trace_q.push_back(15'd0);
        tick();
        rst = 1'b0;
        tick();
        // basic pass, A all ones, B = 1..8
        load_fifos(0);
        run_pass(0, 0, -1, -1, -1, 1'b0, -1, 0, 20);
        // refused start: A FIFO 3 not full
        load_fifos(1);
        force_a3 = 1'b1;
        run_pass(1, 1, -1, -1, -1, 1'b0, -1, 0, 4);
        force_a3 = 1'b0;
        // second start mid-pass is ignored
        run_pass(0, 1, 5, -1, -1, 1'b0, -1, 0, 22);
        // back-to-back: start in DONE ignored, next IDLE cycle accepted
        load_fifos(0);
        run_pass(0, 0, 19, -1, -1, 1'b0, 19, 1, 20);
        run_pass(0, 1, -1, -1, -1, 1'b0, -1, 0, 21);
        // B empty flag during FEED
        load_fifos(0);
        run_pass(0, 0, -1, -1, 7, 1'b0, -1, 0, 22);
        // reset during FEED, then a fresh pass
        load_fifos(1);
        run_pass(0, 1, -1, 6, -1, 1'b1, -1, 0, 10);
        load_fifos(0);
        run_pass(0, 0, -1, -1, -1, 1'b0, -1, 0, 21);
        stim_done = 1'b1;
    end

    initial begin
        int          cyc;
        logic [14:0] exp_v;
        logic [14:0] got_v;
        res_t        r;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (trace_q.size() > 0) begin
                exp_v = trace_q.pop_front();
                got_v = {start_err, underflow, busy, done, mac_clr, mac_en, b_rdreq, a_rdreq};
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL trace cyc=%0d got={err,uf,busy,done,clr,en,brd,ard}=%b want=%b",
                             cyc, got_v, exp_v);
                end
                if (start_err === 1'b1) $display("txn start refused at cyc=%0d", cyc);
            end
            if (done === 1'b1) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 want no pass pending", cyc);
                end else begin
                    r = res_q.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        total++;
                        if (acc_m[i] != int'(r.acc[i])) begin
                            bad++;
                            $display("FAIL acc%0d cyc=%0d got=%0d want=%0d", i, cyc, acc_m[i], r.acc[i]);
                        end
                    end
                    total++;
                    if (perf_cycles !== r.perf) begin
                        bad++;
                        $display("FAIL perf cyc=%0d got=%0d want=%0d", cyc, perf_cycles, r.perf);
                    end
                    $display("txn done cyc=%0d acc0=%0d acc7=%0d perf=%0d", cyc, acc_m[0], acc_m[7], perf_cycles);
                end
            end
            if (stim_done) begin
                total++;
                if (trace_q.size() != 0 || res_q.size() != 0) begin
                    bad++;
                    $display("FAIL leftover got trace=%0d results=%0d want 0 and 0", trace_q.size(), res_q.size());
                end
                total++;
                if (perf_cycles !== PERF_EXP) begin
                    bad++;
                    $display("FAIL perf_final got=%0d want=%0d", perf_cycles, PERF_EXP);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (cyc > 4000) begin
                total++;
                bad++;
                $display("FAIL timeout got cyc=%0d want stimulus finished", cyc);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule
